// File: rtl/biriq_cmpu_pkg.sv
// biriq_cmpu_pkg: op encodings, branch-condition codes and writeback record for biriq_cmpu.
package biriq_cmpu_pkg;
    localparam int MAX_XLEN  = 64;
    localparam int MAX_TAG_W = 16;

    typedef enum logic [3:0] {
        OP_MAXU  = 4'b0000,
        OP_MINU  = 4'b0001,
        OP_SLT   = 4'b0010,
        OP_SLTU  = 4'b0011,
        OP_MAX   = 4'b0100,
        OP_MIN   = 4'b0101,
        OP_CZEQZ = 4'b0110,
        OP_CZNEZ = 4'b0111,
        OP_BEQ   = 4'b1000,
        OP_BNE   = 4'b1001,
        OP_BLT   = 4'b1100,
        OP_BGE   = 4'b1101,
        OP_BLTU  = 4'b1110,
        OP_BGEU  = 4'b1111
    } op_e;

    // Branch condition lives in op[2:1]; op[0] inverts it.
    localparam logic [1:0] BR_EQ  = 2'b00;
    localparam logic [1:0] BR_LT  = 2'b10;
    localparam logic [1:0] BR_LTU = 2'b11;

    typedef struct packed {
        logic [MAX_XLEN-1:0]  result;
        logic [MAX_TAG_W-1:0] tag;
        logic                 is_branch;
        logic                 taken;
        logic                 mispredict;
        logic [MAX_XLEN-1:0]  redirect;
    } res_t;

    function automatic logic is_branch_op(logic [3:0] op);
        return op[3] && op[2:1] != 2'b01;
    endfunction
endpackage

// File: rtl/biriq_cmpu_cmp.sv
// biriq_cmpu_cmp: full-width equality plus signed/unsigned greater-than from sign bits and low-bit compare.
module biriq_cmpu_cmp
    import biriq_cmpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            eq_o,
    output logic            gt_s_o,
    output logic            gt_u_o
);
    logic same_sign;
    logic lo_gt;

    assign same_sign = a_i[XLEN-1] == b_i[XLEN-1];
    assign lo_gt     = a_i[XLEN-2:0] > b_i[XLEN-2:0];
    assign eq_o      = a_i == b_i;
    assign gt_u_o    = same_sign ? lo_gt : a_i[XLEN-1];
    assign gt_s_o    = same_sign ? lo_gt : b_i[XLEN-1];
endmodule

// File: rtl/biriq_cmpu.sv
// biriq_cmpu: two-stage compare/min-max/czero/branch unit with valid/ready on both sides.
// Define BIRIQ_CMPU_ZBB_EN to implement max/min/maxu/minu; otherwise those encodings are reserved.
module biriq_cmpu
    import biriq_cmpu_pkg::*;
#(
    parameter int XLEN                  = 32,
    parameter int TAG_W                 = 6,
    parameter int C_HAS_CZERO_EXTENSION = 1
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             is_branch_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o
);
    logic             s1_v_q, s2_v_q;
    op_e              s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [XLEN-1:0]  s1_a_q, s1_b_q, s1_pc4_q, s1_pcimm_q;
    logic             s1_eq_q, s1_gts_q, s1_gtu_q, s1_pred_q;
    logic             eq, gt_s, gt_u;
    logic             s1_adv, s2_adv, accept;
    logic             lt_s, lt_u, b_zero, br, cond, taken;
    logic [XLEN-1:0]  res;
    res_t             s2_d, s2_q;
    logic             unused_s2;

    biriq_cmpu_cmp #(.XLEN(XLEN)) u_cmp (
        .a_i   (a_i),
        .b_i   (b_i),
        .eq_o  (eq),
        .gt_s_o(gt_s),
        .gt_u_o(gt_u)
    );

    assign s2_adv  = !s2_v_q || ready_i;
    assign s1_adv  = !s1_v_q || s2_adv;
    assign ready_o = s1_adv;
    assign accept  = valid_i && s1_adv && !flush_i;

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s2_q   <= '0;
        end else if (flush_i) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) s2_q <= s2_d;
            end
            if (s1_adv) s1_v_q <= valid_i;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (accept) begin
            s1_op_q    <= op_e'(op_i);
            s1_tag_q   <= tag_i;
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
            s1_eq_q    <= eq;
            s1_gts_q   <= gt_s;
            s1_gtu_q   <= gt_u;
            s1_pred_q  <= pred_taken_i;
            s1_pc4_q   <= pc_i + XLEN'(4);
            s1_pcimm_q <= pc_i + imm_i;
        end
    end

    always_comb begin
        lt_s   = !s1_eq_q && !s1_gts_q;
        lt_u   = !s1_eq_q && !s1_gtu_q;
        b_zero = s1_b_q == '0;
        res    = '0;
        case (s1_op_q)
`ifdef BIRIQ_CMPU_ZBB_EN
            OP_MAXU:  res = s1_gtu_q ? s1_a_q : s1_b_q;
            OP_MINU:  res = s1_gtu_q ? s1_b_q : s1_a_q;
            OP_MAX:   res = s1_gts_q ? s1_a_q : s1_b_q;
            OP_MIN:   res = s1_gts_q ? s1_b_q : s1_a_q;
`endif
            OP_SLT:   res = XLEN'(lt_s);
            OP_SLTU:  res = XLEN'(lt_u);
            OP_CZEQZ: res = (C_HAS_CZERO_EXTENSION != 0 && !b_zero) ? s1_a_q : '0;
            OP_CZNEZ: res = (C_HAS_CZERO_EXTENSION != 0 && b_zero) ? s1_a_q : '0;
            default:  res = '0;
        endcase
        br    = is_branch_op(s1_op_q);
        cond  = s1_op_q[2:1] == BR_EQ ? s1_eq_q : s1_op_q[2:1] == BR_LT ? lt_s : lt_u;
        taken = br && (cond ^ s1_op_q[0]);
        s2_d            = '0;
        s2_d.result     = MAX_XLEN'(br ? s1_pc4_q : res);
        s2_d.tag        = MAX_TAG_W'(s1_tag_q);
        s2_d.is_branch  = br;
        s2_d.taken      = taken;
        s2_d.mispredict = br && (taken ^ s1_pred_q);
        s2_d.redirect   = br ? MAX_XLEN'(taken ? s1_pcimm_q : s1_pc4_q) : '0;
    end

    assign valid_o       = s2_v_q;
    assign result_o      = s2_q.result[XLEN-1:0];
    assign tag_o         = s2_q.tag[TAG_W-1:0];
    assign is_branch_o   = s2_q.is_branch;
    assign taken_o       = s2_q.taken;
    assign mispredict_o  = s2_q.mispredict;
    assign redirect_pc_o = s2_q.redirect[XLEN-1:0];
    // Record fields are sized for the widest build; the spare high bits are intentionally dropped.
    assign unused_s2     = ^s2_q;
endmodule

// File: tb/tb_biriq_cmpu.sv
// tb_biriq_cmpu: drives a 32-bit and a 64-bit biriq_cmpu in lockstep against a behavioural queue model.
module tb_biriq_cmpu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid, rdy_i, pred;
    logic [3:0]  op;
    logic [5:0]  tag;
    logic [63:0] a, b, pc, imm;

    logic        r32_ready, r32_valid, r32_isb, r32_tk, r32_mp;
    logic [31:0] r32_res, r32_rd;
    logic [5:0]  r32_tag;
    logic        r64_ready, r64_valid, r64_isb, r64_tk, r64_mp;
    logic [63:0] r64_res, r64_rd;
    logic [5:0]  r64_tag;

    biriq_cmpu #(.XLEN(32)) u32 (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(r32_ready),
        .op_i(op), .tag_i(tag), .a_i(a[31:0]), .b_i(b[31:0]), .pc_i(pc[31:0]), .imm_i(imm[31:0]),
        .pred_taken_i(pred), .valid_o(r32_valid), .ready_i(rdy_i), .result_o(r32_res), .tag_o(r32_tag),
        .is_branch_o(r32_isb), .taken_o(r32_tk), .mispredict_o(r32_mp), .redirect_pc_o(r32_rd)
    );

    biriq_cmpu #(.XLEN(64)) u64 (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(r64_ready),
        .op_i(op), .tag_i(tag), .a_i(a), .b_i(b), .pc_i(pc), .imm_i(imm),
        .pred_taken_i(pred), .valid_o(r64_valid), .ready_i(rdy_i), .result_o(r64_res), .tag_o(r64_tag),
        .is_branch_o(r64_isb), .taken_o(r64_tk), .mispredict_o(r64_mp), .redirect_pc_o(r64_rd)
    );

`ifdef BIRIQ_CMPU_ZBB_EN
    localparam bit ZBB = 1'b1;
`else
    localparam bit ZBB = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] res;
        logic        isb;
        logic        tk;
        logic        mp;
        logic [63:0] rd;
    } exp_t;

    typedef struct {
        exp_t       e32;
        exp_t       e64;
        logic [5:0] tag;
        int         stage;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic [5:0] saved_tag;

    function automatic exp_t model(input logic [3:0] o, input logic [63:0] aa, input logic [63:0] bb,
                                   input logic [63:0] pp, input logic [63:0] ii, input logic pr, input int w);
        exp_t e;
        logic [63:0] m, ua, ub;
        logic signed [63:0] sa, sb;
        logic tk;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        ua = aa & m;
        ub = bb & m;
        sa = (w == 64) ? aa : {{32{aa[31]}}, aa[31:0]};
        sb = (w == 64) ? bb : {{32{bb[31]}}, bb[31:0]};
        e  = '0;
        tk = 1'b0;
        case (o)
            4'h0: e.res = ZBB ? ((ua > ub) ? ua : ub) : 64'd0;
            4'h1: e.res = ZBB ? ((ua < ub) ? ua : ub) : 64'd0;
            4'h2: e.res = (sa < sb) ? 64'd1 : 64'd0;
            4'h3: e.res = (ua < ub) ? 64'd1 : 64'd0;
            4'h4: e.res = ZBB ? ((sa > sb) ? ua : ub) : 64'd0;
            4'h5: e.res = ZBB ? ((sa < sb) ? ua : ub) : 64'd0;
            4'h6: e.res = (ub == 0) ? 64'd0 : ua;
            4'h7: e.res = (ub != 0) ? 64'd0 : ua;
            4'h8: begin e.isb = 1'b1; tk = ua == ub;  end
            4'h9: begin e.isb = 1'b1; tk = ua != ub;  end
            4'hC: begin e.isb = 1'b1; tk = sa < sb;   end
            4'hD: begin e.isb = 1'b1; tk = sa >= sb;  end
            4'hE: begin e.isb = 1'b1; tk = ua < ub;   end
            4'hF: begin e.isb = 1'b1; tk = ua >= ub;  end
            default: e.res = 64'd0;
        endcase
        if (e.isb) begin
            e.tk  = tk;
            e.mp  = tk ^ pr;
            e.res = (pp + 64'd4) & m;
            e.rd  = tk ? ((pp + ii) & m) : ((pp + 64'd4) & m);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
        end
    endtask

    task automatic chk_zero();
        chk("rst_res32", r32_res, 0);  chk("rst_res64", r64_res, 0);
        chk("rst_tag32", r32_tag, 0);  chk("rst_tag64", r64_tag, 0);
        chk("rst_rd32", r32_rd, 0);    chk("rst_rd64", r64_rd, 0);
        chk("rst_flags32", {r32_isb, r32_tk, r32_mp}, 0);
        chk("rst_flags64", {r64_isb, r64_tk, r64_mp}, 0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic exp_ready, exp_valid;
        ent_t f;
        @(negedge clk);
        exp_ready = !(q.size() == 2 && !rdy_i);
        exp_valid = q.size() > 0 && q[0].stage == 2;
        chk("ready32", r32_ready, exp_ready);
        chk("ready64", r64_ready, exp_ready);
        chk("valid32", r32_valid, exp_valid);
        chk("valid64", r64_valid, exp_valid);
        if (exp_valid) begin
            f = q[0];
            chk("tag32", r32_tag, f.tag);          chk("tag64", r64_tag, f.tag);
            chk("res32", r32_res, f.e32.res);      chk("res64", r64_res, f.e64.res);
            chk("isb32", r32_isb, f.e32.isb);      chk("isb64", r64_isb, f.e64.isb);
            chk("tk32", r32_tk, f.e32.tk);         chk("tk64", r64_tk, f.e64.tk);
            chk("mp32", r32_mp, f.e32.mp);         chk("mp64", r64_mp, f.e64.mp);
            chk("rd32", r32_rd, f.e32.rd);         chk("rd64", r64_rd, f.e64.rd);
        end
        @(posedge clk);
        if (rst || flush) q.delete();
        else begin
            if (exp_valid && rdy_i) void'(q.pop_front());
            if (q.size() > 0 && q[0].stage == 1) q[0].stage = 2;
            if (valid && exp_ready) begin
                f.e32 = model(op, a, b, pc, imm, pred, 32);
                f.e64 = model(op, a, b, pc, imm, pred, 64);
                f.tag = tag;
                f.stage = 1;
                q.push_back(f);
            end
        end
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [63:0] aa, input logic [63:0] bb,
                         input logic [63:0] pp, input logic [63:0] ii, input logic pr);
        valid = 1'b1; op = o; a = aa; b = bb; pc = pp; imm = ii; pred = pr;
        tag = 6'($urandom);
    endtask

    function automatic logic [63:0] rnd();
        case ($urandom_range(5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return {32'h0, $urandom} | 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1; flush = 0; valid = 0; rdy_i = 1; pred = 0; op = 0; tag = 0;
        a = 0; b = 0; pc = 0; imm = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        chk_zero();
        rst = 0;
        cycle();

`ifdef BIRIQ_CMPU_ZBB_EN
        issue(4'h4, 64'hFFFF_FFFF, 64'd1, 0, 0, 0);
        cycle(); valid = 0; cycle();
        chk("max_valid", r32_valid, 1);
        chk("max_res", r32_res, 64'd1);
        issue(4'h0, 64'hFFFF_FFFF, 64'd1, 0, 0, 0);
        cycle(); valid = 0; cycle();
        chk("maxu_res", r32_res, 64'hFFFF_FFFF);
`else
        issue(4'h4, 64'hFFFF_FFFF, 64'd1, 0, 0, 0);
        cycle(); valid = 0; cycle();
        chk("rsv_valid", r32_valid, 1);
        chk("rsv_res", r32_res, 0);
        chk("rsv_isb", r32_isb, 0);
`endif
        cycle();

        issue(4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h100, 64'h40, 0);
        cycle(); valid = 0; cycle();
        chk("blt_tk32", r32_tk, 1);     chk("blt_mp32", r32_mp, 1);
        chk("blt_rd32", r32_rd, 64'h140); chk("blt_res32", r32_res, 64'h104);
        chk("blt_tk64", r64_tk, 1);     chk("blt_rd64", r64_rd, 64'h140);
        cycle();

        issue(4'h3, 64'h8000_0000_0000_0000, 64'd1, 0, 0, 0);
        cycle();
        issue(4'h7, 64'h1234_5678_9ABC_DEF0, 64'd5, 0, 0, 0);
        cycle();
        chk("sltu64", r64_res, 0);
        issue(4'h7, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, 0, 0);
        cycle();
        chk("cznez_b5", r64_res, 0);
        valid = 0;
        cycle();
        chk("cznez_b0", r64_res, 64'h1234_5678_9ABC_DEF0);
        cycle();

        rdy_i = 1;
        issue(4'h2, rnd(), rnd(), 0, 0, 0); cycle();
        rdy_i = 0;
        issue(4'h9, rnd(), rnd(), rnd(), rnd(), 1); cycle();
        issue(4'hE, rnd(), rnd(), rnd(), rnd(), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_ready", r32_ready, 0);
        end
        rdy_i = 1;
        cycle();
        valid = 0;
        repeat (4) cycle();

        issue(4'h3, rnd(), rnd(), 0, 0, 0); cycle();
        issue(4'h8, rnd(), rnd(), rnd(), rnd(), 0); cycle();
        issue(4'h2, rnd(), rnd(), 0, 0, 0); flush = 1; cycle();
        flush = 0; valid = 0;
        repeat (3) cycle();
        issue(4'hD, rnd(), rnd(), rnd(), rnd(), 1);
        saved_tag = tag;
        cycle(); valid = 0; cycle();
        chk("post_flush_valid", r32_valid, 1);
        chk("post_flush_tag", r32_tag, saved_tag);
        cycle();

        issue(4'h2, rnd(), rnd(), 0, 0, 0); cycle();
        issue(4'hF, rnd(), rnd(), rnd(), rnd(), 0); cycle();
        rst = 1; flush = 1; cycle();
        rst = 0; flush = 0; valid = 0;
        chk_zero();
        repeat (3) begin
            cycle();
            chk("rst_no_valid", r64_valid, 0);
        end

        for (int i = 0; i < 400; i++) begin
            rst   = $urandom_range(99) == 0;
            flush = $urandom_range(29) == 0;
            rdy_i = $urandom_range(3) != 0;
            if ($urandom_range(9) < 7) begin
                issue(4'($urandom_range(15)), rnd(), rnd(), rnd(), rnd(), 1'($urandom));
                if ($urandom_range(3) == 0) b = a;
            end else valid = 0;
            cycle();
        end
        rst = 0; flush = 0; rdy_i = 1; valid = 0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/biriq_cmpu.md
BIRIQ_CMPU -- requirements
Module: biriq_cmpu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 6, width of the ROB tag carried with each op.
REQ-003 SHALL have parameter C_HAS_CZERO_EXTENSION, default 1; 0 makes ops 0110/0111 reserved.
REQ-004 cpu_clock_i  in  1  sole clock; all state updates on rising edge.
REQ-005 cpu_reset_i  in  1  synchronous, active-high reset.
REQ-006 flush_i  in  1  kill all in-flight ops.
REQ-007 valid_i / ready_o  in / out  1 / 1  issue handshake; transfer when both high.
REQ-008 op_i  in  4  operation; tag_i  in  TAG_W  ROB tag.
REQ-009 a_i, b_i, pc_i, imm_i  in  XLEN each  rs1, rs2/imm, branch PC, branch offset.
REQ-010 pred_taken_i  in  1  frontend prediction for branch ops.
REQ-011 valid_o / ready_i  out / in  1 / 1  writeback handshake.
REQ-012 result_o  out  XLEN; tag_o  out  TAG_W; is_branch_o, taken_o, mispredict_o  out  1 each; redirect_pc_o  out  XLEN.

Function
REQ-013 Op encoding SHALL be: 0000 maxu, 0001 minu, 0010 slt, 0011 sltu, 0100 max, 0101 min, 0110 czero.eqz, 0111 czero.nez, 1000 beq, 1001 bne, 1100 blt, 1101 bge, 1110 bltu, 1111 bgeu; 1010/1011 reserved.
REQ-014 Two-stage pipeline SHALL be used: S1 registers op, tag, a, b, eq, signed/unsigned greater-than flags, pc+4 and pc+imm; S2 registers all outputs.
REQ-015 Latency SHALL be exactly 2 cycles from accepted issue to valid_o with ready_i held high; throughput one op per cycle.
REQ-016 Each stage SHALL advance when it is empty or the stage after it advances; ready_o = !S1.valid | S1 advances (no combinational path valid_i -> ready_o).
REQ-017 When ready_i is low and S2 is valid, S2 and its outputs SHALL hold stable; valid_o SHALL never drop without a handshake unless flushed.
REQ-018 Comparisons SHALL be full XLEN: signed via sign bits plus lower XLEN-1 bit compare, unsigned via same.
REQ-019 slt/sltu SHALL return 1 zero-extended to XLEN when a<b; czero.eqz SHALL return 0 when b==0 else a; czero.nez SHALL return 0 when b!=0 else a.
REQ-020 Branch ops SHALL set is_branch_o=1, result_o=pc+4, taken_o per condition, redirect_pc_o = taken ? pc+imm : pc+4 (mod 2^XLEN), mispredict_o = taken_o ^ pred_taken.
REQ-021 Non-branch ops SHALL drive is_branch_o, taken_o, mispredict_o = 0 and redirect_pc_o = 0.
REQ-022 Reserved ops SHALL complete normally with result_o = 0 and no branch flags.
REQ-023 flush_i SHALL invalidate S1 and S2 next cycle; an op presented with flush_i high SHALL NOT be accepted; flush has priority over issue and stall.

Reset
REQ-024 cpu_reset_i SHALL clear S1/S2 valid; valid_o=0, ready_o=1 after reset; result_o, tag_o, redirect_pc_o, is_branch_o, taken_o, mispredict_o = 0.
REQ-025 Reset mid-operation SHALL drop in-flight ops without any valid_o pulse; reset has priority over flush.

Configuration
REQ-026 Macro BIRIQ_CMPU_ZBB_EN: defined -> max/min/maxu/minu implemented per REQ-013; undefined -> those four encodings are reserved (REQ-022), comparator logic for them removed.

Structure
REQ-027 Op encoding enum, branch-condition constants and a result struct (result, tag, branch flags, redirect) SHALL live in shared package biriq_cmpu_pkg.
REQ-028 One sub-module biriq_cmpu_cmp SHALL hold the combinational XLEN compare (eq, gt signed, gt unsigned).

Verification
REQ-029 max, a=0xFFFF_FFFF, b=1, ready_i=1 -> valid_o at cycle 2, result_o=1; maxu same operands -> 0xFFFF_FFFF.
REQ-030 blt pc=0x100, imm=0x40, a=-1, b=0, pred_taken=0 -> taken_o=1, mispredict_o=1, redirect_pc_o=0x140, result_o=0x104.
REQ-031 Back-to-back 3 ops, ready_i low 4 cycles after first -> ready_o low once pipe full, outputs stable, all 3 retire in order with correct tags.
REQ-032 flush_i with 2 ops in flight and valid_i high -> no valid_o following, incoming op not accepted, next op after flush completes in 2 cycles.
REQ-033 XLEN=64 sltu a=0x8000_0000_0000_0000, b=1 -> result_o=0; czero.nez b=5 -> 0; b=0 -> a.
REQ-034 Build without BIRIQ_CMPU_ZBB_EN, op 0100 -> result_o=0, is_branch_o=0; reset asserted mid-stream -> valid_o stays 0.
